// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its requester arbiter: op-code encodings,
// control width and the arbiter FSM states.
package alu_pkg;

  localparam int ALU_CTRL_W = 4;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_ANDN = 4'd3;
  localparam logic [3:0] ALU_ORN  = 4'd4;
  localparam logic [3:0] ALU_ADD  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SRA  = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Core combinational ALU. Overflow is the carry-out of ADD and 0 for all other
// codes; unknown codes produce a zero result.
import alu_pkg::*;

module alu_core #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]       a,
  input  logic [XLEN-1:0]       b,
  input  logic [ALU_CTRL_W-1:0] ctrl,
  output logic [XLEN-1:0]       result,
  output logic                  of
);

  logic [XLEN:0] sum;
  logic [4:0]    shamt;

  // Operation select
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    shamt  = b[4:0];
    result = '0;
    of     = 1'b0;
    case (ctrl)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_ANDN: result = a & ~b;
      ALU_ORN:  result = a | ~b;
      ALU_ADD: begin
        result = sum[XLEN-1:0];
        of     = sum[XLEN];
      end
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_rr.sv
// Combinational round-robin picker: first set request at or above ptr, with
// wrap, returned both one-hot and as an index.
import alu_pkg::*;

module alu_share_rr #(
  parameter int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic             hit;

  // Scan upward from ptr; the first hit claims the grant
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    hit   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      sum = (sum >= (IDX_W+1)'(N_REQ)) ? (sum - (IDX_W+1)'(N_REQ)) : sum;
      cand = sum[IDX_W-1:0];
      hit = ~found & req[cand];
      grant[cand] = grant[cand] | hit;
      idx = hit ? cand : idx;
      found = found | hit;
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between N_REQ valid/ready requesters, one transaction in flight.
// Define ALU_SHARE_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
import alu_pkg::*;

module alu_share_arb #(
  parameter int N_REQ = 2,
  parameter int XLEN  = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req_valid,
  output logic [N_REQ-1:0]        o_req_ready,
  input  logic [N_REQ*XLEN-1:0]   i_req_a,
  input  logic [N_REQ*XLEN-1:0]   i_req_b,
  input  logic [N_REQ*4-1:0]      i_req_ctrl,
  output logic [N_REQ-1:0]        o_rsp_valid,
  input  logic [N_REQ-1:0]        i_rsp_ready,
  output logic [XLEN-1:0]         o_rsp_result,
  output logic                    o_rsp_of,
  output logic                    o_busy
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t                state;
  state_t                next_state;
  logic [IDX_W-1:0]      pick_ptr;
  logic [N_REQ-1:0]      grant;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      owner;
  logic [XLEN-1:0]       a_q;
  logic [XLEN-1:0]       b_q;
  logic [ALU_CTRL_W-1:0] ctrl_q;
  logic [XLEN-1:0]       alu_result;
  logic                  alu_of;
  logic [XLEN-1:0]       result_q;
  logic                  of_q;
  logic [N_REQ-1:0]      rsp_valid_q;
  logic                  req_fire;
  logic                  rsp_fire;

`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [IDX_W-1:0] rr_ptr;

  // Pointer advances past the winner on every grant
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_ptr <= '0;
    end else if (req_fire) begin
      rr_ptr <= (grant_idx == IDX_W'(N_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
    end else begin
      rr_ptr <= rr_ptr;
    end
  end

  assign pick_ptr = rr_ptr;
`endif

  alu_share_rr #(.N_REQ(N_REQ)) u_rr (
    .req   (i_req_valid),
    .ptr   (pick_ptr),
    .grant (grant),
    .idx   (grant_idx)
  );

  alu_core #(.XLEN(XLEN)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .ctrl   (ctrl_q),
    .result (alu_result),
    .of     (alu_of)
  );

  assign req_fire    = (state == IDLE) && (|grant);
  assign rsp_fire    = (state == RESP) && i_rsp_ready[owner];
  assign o_req_ready = (state == IDLE) ? grant : '0;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_result = result_q;
  assign o_rsp_of    = of_q;
  assign o_busy      = (state != IDLE);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_fire) next_state = EXEC;
        else          next_state = IDLE;
      end
      EXEC: next_state = RESP;
      RESP: begin
        if (rsp_fire) next_state = IDLE;
        else          next_state = RESP;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand capture on request handshake
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q    <= '0;
      b_q    <= '0;
      ctrl_q <= '0;
      owner  <= '0;
    end else if (req_fire) begin
      a_q    <= i_req_a[grant_idx*XLEN +: XLEN];
      b_q    <= i_req_b[grant_idx*XLEN +: XLEN];
      ctrl_q <= i_req_ctrl[grant_idx*ALU_CTRL_W +: ALU_CTRL_W];
      owner  <= grant_idx;
    end else begin
      a_q    <= a_q;
      b_q    <= b_q;
      ctrl_q <= ctrl_q;
      owner  <= owner;
    end
  end

  // Result and response-valid registers; held until the owner accepts
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      result_q    <= '0;
      of_q        <= 1'b0;
      rsp_valid_q <= '0;
    end else if (state == EXEC) begin
      result_q    <= alu_result;
      of_q        <= alu_of;
      rsp_valid_q <= {{(N_REQ-1){1'b0}}, 1'b1} << owner;
    end else if (rsp_fire) begin
      result_q    <= result_q;
      of_q        <= of_q;
      rsp_valid_q <= '0;
    end else begin
      result_q    <= result_q;
      of_q        <= of_q;
      rsp_valid_q <= rsp_valid_q;
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb (N_REQ=2, XLEN=32).
module tb_alu_share_arb;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_ANDN = 4'd3;
  localparam logic [3:0] OP_ORN  = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [7:0]  req_ctrl;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_of;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  alu_share_arb #(.N_REQ(2), .XLEN(32)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .i_req_ctrl   (req_ctrl),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_result (rsp_result),
    .o_rsp_of     (rsp_of),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  // Call at a falling edge; returns at the falling edge of the EXEC cycle.
  task automatic send(input int r, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] c, output int wcyc);
    req_a[r*32 +: 32] = a;
    req_b[r*32 +: 32] = b;
    req_ctrl[r*4 +: 4] = c;
    req_valid[r] = 1'b1;
    wcyc = 0;
    #1;
    while (req_ready[r] !== 1'b1 && wcyc < 20) begin
      @(negedge clk); #1;
      wcyc++;
    end
    @(negedge clk);
    req_valid[r] = 1'b0;
  endtask

  task automatic get_rsp(input int r, output int cyc);
    cyc = 0;
    #1;
    while (rsp_valid[r] !== 1'b1 && cyc < 20) begin
      @(negedge clk); #1;
      cyc++;
    end
  endtask

  task automatic accept(input int r);
    rsp_ready[r] = 1'b1;
    @(negedge clk);
    rsp_ready[r] = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({req_ready, rsp_valid, rsp_result, rsp_of, busy} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b vld=%b res=%h of=%b busy=%b, want all 0",
               req_ready, rsp_valid, rsp_result, rsp_of, busy);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_add();
    int w, cyc;
    @(negedge clk);
    send(0, 32'd5, 32'd7, OP_ADD, w);
    get_rsp(0, cyc);
    n_tests++;
    if (cyc !== 1) begin
      n_fail++;
      $display("FAIL add_latency: got %0d extra cycles after EXEC, want 1", cyc);
    end
    n_tests++;
    if ({rsp_valid, rsp_of, rsp_result} !== {2'b01, 1'b0, 32'd12}) begin
      n_fail++;
      $display("FAIL add_result: got vld=%b of=%b res=%h, want 01 0 0000000c",
               rsp_valid, rsp_of, rsp_result);
    end
    accept(0);
  endtask

  task automatic test_overflow();
    int w, cyc;
    @(negedge clk);
    send(1, 32'hFFFF_FFFF, 32'd1, OP_ADD, w);
    get_rsp(1, cyc);
    n_tests++;
    if ({rsp_valid, rsp_of, rsp_result} !== {2'b10, 1'b1, 32'h0000_0000}) begin
      n_fail++;
      $display("FAIL add_overflow: got vld=%b of=%b res=%h, want 10 1 00000000",
               rsp_valid, rsp_of, rsp_result);
    end
    accept(1);
    send(1, 32'hFFFF_FFFF, 32'd1, OP_SUB, w);
    get_rsp(1, cyc);
    n_tests++;
    if ({rsp_of, rsp_result} !== {1'b0, 32'hFFFF_FFFE}) begin
      n_fail++;
      $display("FAIL sub_no_of: got of=%b res=%h, want 0 fffffffe", rsp_of, rsp_result);
    end
    accept(1);
  endtask

  task automatic test_ops();
    logic [3:0]  ops [10] = '{OP_AND, OP_OR, OP_XOR, OP_ANDN, OP_ORN,
                              OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA};
    logic [31:0] va  [10] = '{32'h0000_F0F0, 32'h0000_F0F0, 32'h0000_F0F0, 32'h0000_F0F0,
                              32'h0000_F0F0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001,
                              32'h8000_0000, 32'h8000_0000};
    logic [31:0] vb  [10] = '{32'h0000_FF00, 32'h0000_FF00, 32'h0000_FF00, 32'h0000_FF00,
                              32'h0000_FF00, 32'h0000_0001, 32'h0000_0001, 32'd33,
                              32'd4, 32'd4};
    logic [31:0] ve  [10] = '{32'h0000_F000, 32'h0000_FFF0, 32'h0000_0FF0, 32'h0000_00F0,
                              32'hFFFF_F0FF, 32'h0000_0001, 32'h0000_0000, 32'h0000_0002,
                              32'h0800_0000, 32'hF800_0000};
    int w, cyc;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      send(0, va[i], vb[i], ops[i], w);
      get_rsp(0, cyc);
      n_tests++;
      if ({rsp_of, rsp_result} !== {1'b0, ve[i]}) begin
        n_fail++;
        $display("FAIL op_%0d: got of=%b res=%h, want 0 %h", ops[i], rsp_of, rsp_result, ve[i]);
      end
      accept(0);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_g;
    logic [31:0] exp_r;
    int w;
    rst = 1'b1;
    req_a = {32'd10, 32'd1};
    req_b = {32'd10, 32'd1};
    req_ctrl = {OP_ADD, OP_ADD};
    req_valid = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
`endif
      exp_r = (exp_g == 2'b01) ? 32'd2 : 32'd20;
      w = 0;
      #1;
      while (req_ready === 2'b00 && w < 20) begin
        @(negedge clk); #1;
        w++;
      end
      n_tests++;
      if (req_ready !== exp_g || w !== 0) begin
        n_fail++;
        $display("FAIL rr_grant_%0d: got ready=%b after %0d waits, want %b after 0",
                 t, req_ready, w, exp_g);
      end
      @(negedge clk);
      @(negedge clk); #1;
      n_tests++;
      if ({rsp_valid, rsp_result} !== {exp_g, exp_r}) begin
        n_fail++;
        $display("FAIL rr_rsp_%0d: got vld=%b res=%h, want %b %h",
                 t, rsp_valid, rsp_result, exp_g, exp_r);
      end
      rsp_ready = 2'b11;
      @(negedge clk);
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    int w, cyc;
    @(negedge clk);
    send(1, 32'd100, 32'd23, OP_ADD, w);
    get_rsp(1, cyc);
    req_a[31:0] = 32'd2;
    req_b[31:0] = 32'd2;
    req_ctrl[3:0] = OP_ADD;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_tests++;
      if ({rsp_valid, busy, req_ready, rsp_result} !== {2'b10, 1'b1, 2'b00, 32'd123}) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got vld=%b busy=%b ready=%b res=%h, want 10 1 00 0000007b",
                 i, rsp_valid, busy, req_ready, rsp_result);
      end
    end
    accept(1);
    #1;
    n_tests++;
    if ({req_ready, busy} !== {2'b01, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_next_grant: got ready=%b busy=%b, want 01 0", req_ready, busy);
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    get_rsp(0, cyc);
    n_tests++;
    if (rsp_result !== 32'd4) begin
      n_fail++;
      $display("FAIL bp_follow: got res=%h, want 00000004", rsp_result);
    end
    accept(0);
  endtask

  task automatic test_reset_mid_op();
    int w, seen;
    @(negedge clk);
    send(0, 32'd3, 32'd4, OP_SLL, w);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({req_ready, rsp_valid, rsp_result, rsp_of, busy} !== 38'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got ready=%b vld=%b res=%h of=%b busy=%b, want all 0",
               req_ready, rsp_valid, rsp_result, rsp_of, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (rsp_valid !== 2'b00 || busy !== 1'b0) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_no_rsp: got %0d cycles with response/busy, want 0", seen);
    end
    req_a = {32'd1, 32'd3};
    req_b = {32'd1, 32'd4};
    req_ctrl = {OP_ADD, OP_SLL};
    req_valid = 2'b11;
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_mid_first_grant: got ready=%b, want 01", req_ready);
    end
    @(negedge clk);
    req_valid = 2'b00;
    get_rsp(0, w);
    n_tests++;
    if (rsp_result !== 32'd48) begin
      n_fail++;
      $display("FAIL rst_mid_sll: got res=%h, want 00000030", rsp_result);
    end
    accept(0);
  endtask

  task automatic test_illegal_op();
    int w, cyc;
    @(negedge clk);
    send(0, 32'hAAAA_5555, 32'd1, 4'hF, w);
    get_rsp(0, cyc);
    n_tests++;
    if ({rsp_valid, rsp_of, rsp_result} !== {2'b01, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL illegal_op: got vld=%b of=%b res=%h, want 01 0 00000000",
               rsp_valid, rsp_of, rsp_result);
    end
    accept(0);
    #1;
    n_tests++;
    if ({busy, rsp_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL illegal_done: got busy=%b vld=%b, want 0 00", busy, rsp_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    req_a = 64'd0;
    req_b = 64'd0;
    req_ctrl = 8'd0;
    rsp_ready = 2'b00;
    test_reset();
    test_single_add();
    test_overflow();
    test_ops();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_illegal_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
